data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, storage depth in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request accept to response valid (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator accepts response.
REQ-013 SHALL have port rsp_rdata  output  32  load data, extended per funct3; 0 for stores.
REQ-014 SHALL have port rsp_err  output  1  misaligned-access flag (see Configuration).

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request when req_valid and req_ready are both 1 at a rising edge, capturing we/addr/wdata/funct3 and leaving IDLE.
REQ-017 SHALL assert rsp_valid exactly LATENCY cycles after the accepting edge; LATENCY=1 skips WAIT (IDLE -> RESP).
REQ-018 SHALL perform the memory access (read sample or write commit) on the edge entering RESP, exactly once per request.
REQ-019 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE on that edge.
REQ-020 SHALL NOT accept a new request in the cycle a response handshakes; the earliest next accept is the following edge.
REQ-021 SHALL index words by req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (address wraps modulo memory size).
REQ-022 SHALL store SB to byte lane addr[1:0], SH to lanes {addr[1],0} and {addr[1],1}, SW to all four lanes; other lanes untouched.
REQ-023 SHALL return loads from the same lanes: B/H sign-extended, BU/HU zero-extended, W unmodified.
REQ-024 SHALL treat unlisted funct3 codes (011, 110, 111) as W.
REQ-025 SHALL ignore req_valid/req_* changes while not in IDLE.

Reset
REQ-026 SHALL, while rst = 0, force state IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; req_ready = 1 from the first edge after release.
REQ-027 SHALL abort any in-flight request on reset; an uncommitted store SHALL NOT be written.
REQ-028 SHALL NOT clear memory contents on reset.

Configuration
REQ-029 With DMEM_MISALIGN_ERR_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 SHALL suppress the write, return rsp_rdata = 0 and rsp_err = 1 with normal latency.
REQ-030 Without DMEM_MISALIGN_ERR_EN: misaligned offset bits SHALL be ignored (H uses addr[1], W uses addr[1:0]=00) and rsp_err SHALL be tied 0.

Verification
REQ-031 LATENCY=2: SW addr 0x10 data 0xDEADBEEF accepted at edge 0 -> rsp_valid at edge 2, rdata 0; LW 0x10 -> rdata 0xDEADBEEF.
REQ-032 SB addr 0x13 data 0x80 over word 0 -> LW 0x10 = 0x80ADBEEF; LB 0x13 = 0xFFFFFF80; LBU 0x13 = 0x00000080; LHU 0x12 = 0x000080AD.
REQ-033 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready 0 throughout; release -> IDLE next edge, req_ready 1.
REQ-034 DEPTH_WORDS=1024: SW addr 0x1000 data 0x12345678 -> LW 0x0 returns 0x12345678 (wrap).
REQ-035 With DMEM_MISALIGN_ERR_EN: SW addr 0x22 -> rsp_err 1, LW 0x20 unchanged; without macro: same store writes word 0x20.
REQ-036 rst driven 0 one cycle after SW accept -> rsp_valid 0 immediately, store absent when read back after release.

Source files
------------

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Brief    : Fixed-latency byte-addressable data memory with valid/ready
//            request and response channels and RISC-V style load/store sizes.
//            Optional macro DMEM_MISALIGN_ERR_EN flags misaligned H/W accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        r_live;
    logic        w_accept;
    logic        w_access;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;

    logic        w_cur_we;
    logic [31:0] w_cur_addr;
    logic [31:0] w_cur_wdata;
    logic [2:0]  w_cur_funct3;

    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] w_idx;
    logic [31:0] w_word;
    logic [3:0]  w_be;
    logic [31:0] w_wlanes;
    logic [31:0] w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_is_b;
    logic        w_is_h;
    logic        w_sign;
    logic        w_mis;

    logic        r_valid;
    logic [31:0] r_rdata;
    logic        r_err;

    assign req_ready = r_live && (r_state == S_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = r_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // With LATENCY=1 the access happens on the accepting edge, so decode the live request.
    assign w_cur_we     = (r_state == S_IDLE) ? req_we     : r_we;
    assign w_cur_addr   = (r_state == S_IDLE) ? req_addr   : r_addr;
    assign w_cur_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;
    assign w_cur_funct3 = (r_state == S_IDLE) ? req_funct3 : r_funct3;

    assign w_idx  = w_cur_addr[AW+1:2];
    assign w_word = mem[w_idx];
    assign w_is_b = (w_cur_funct3[1:0] == 2'b00);
    assign w_is_h = (w_cur_funct3[1:0] == 2'b01);
    assign w_sign = ~w_cur_funct3[2];

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_mis = (w_is_h && w_cur_addr[0]) ||
                   (!w_is_b && !w_is_h && (w_cur_addr[1:0] != 2'b00));
`else
    assign w_mis = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_access   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (LATENCY <= 1) begin
                        w_next   = S_RESP;
                        w_access = 1'b1;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = 4'(LATENCY - 2);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next   = S_RESP;
                    w_access = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_be     = 4'b1111;
        w_wlanes = w_cur_wdata;
        w_byte   = w_word[8*w_cur_addr[1:0] +: 8];
        w_half   = w_cur_addr[1] ? w_word[31:16] : w_word[15:0];
        w_load   = w_word;
        if (w_is_b) begin
            w_be     = 4'b0001 << w_cur_addr[1:0];
            w_wlanes = {4{w_cur_wdata[7:0]}};
            w_load   = {{24{w_sign & w_byte[7]}}, w_byte};
        end else if (w_is_h) begin
            w_be     = w_cur_addr[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{w_cur_wdata[15:0]}};
            w_load   = {{16{w_sign & w_half[15]}}, w_half};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_live   <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_funct3 <= 3'd0;
            r_valid  <= 1'b0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_we     <= req_we;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
            end
            if (w_access) begin
                r_valid <= 1'b1;
                r_rdata <= (w_cur_we || w_mis) ? 32'd0 : w_load;
                r_err   <= w_mis;
            end else if (r_state == S_RESP && rsp_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Memory is deliberately not reset; aborted requests never reach w_access.
    always_ff @(posedge clk) begin
        if (w_access && w_cur_we && !w_mis) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
                end
            end
        end
    end

    logic w_unused_addr;
    assign w_unused_addr = ^{1'b0, w_cur_addr[31:AW+2]};

endmodule

`default_nettype wire
